// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state type for the SPI up-counter slave
//
// Purpose : frame geometry and FSM state encoding used by spi_upcounter_slave.
// Ports   : none (package).
package spi_pkg;

  localparam int COUNTER_W  = 14;  // reassembled counter width
  localparam int FRAME_BITS = 16;  // bits per SS assertion (two bytes)
  localparam int PAD_W      = 2;   // leading pad bits in byte0, discarded
  localparam int CNT_W      = 5;   // bit counter width, holds 0..FRAME_BITS

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } spi_slave_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
//
// Purpose : bring one asynchronous pin into the clk domain and flag its edges.
// Ports   : clk, reset (async, active-high), din (async pin),
//           level (synchronized value), rise / fall (1-cycle edge pulses).
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // Edges compare the synchronizer output with its one-cycle-old copy, so a
  // pin edge is acted upon SYNC_STAGES+1 clocks after it happens.
  assign level = sync[SYNC_STAGES-1];
  assign rise  = sync[SYNC_STAGES-1] & ~prev;
  assign fall  = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/spi_upcounter_slave.sv
// rtl/spi_upcounter_slave.sv - SPI mode-0 slave receiving the 14-bit up-counter value
//
// Purpose : oversample SCLK/MOSI/SS_N, reassemble one 16-bit frame per SS
//           assertion and publish the low 14 bits only on complete frames.
// Ports   : clk, reset (async, active-high), sclk, mosi, ss_n (SPI pins),
//           miso (echo of previous value, or 0), o_counter (held value),
//           o_valid (update pulse), o_frame_err (abort pulse), o_busy.
// Config  : SPI_MISO_ECHO_EN builds a tx register that shifts the previously
//           received value back to the master; undefined drives miso to 0.
module spi_upcounter_slave
  import spi_pkg::*;
#(
  parameter int COUNTER_W   = spi_pkg::COUNTER_W,
  parameter int FRAME_BITS  = spi_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 ss_n,
  output logic                 miso,
  output logic [COUNTER_W-1:0] o_counter,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic ss_level,   ss_rise,   ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .reset(reset), .din(ss_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_slave_state_e        state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   shreg_next;

  // mosi passes through the same synchronizer depth as sclk, so its level is
  // aligned with the detected sclk rise.
  assign shreg_next = {shreg[FRAME_BITS-2:0], mosi_level};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_counter   <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (sclk_rise) begin
            shreg <= shreg_next;
            if (bit_cnt != FULL_CNT) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          // A 16th rise landing in the same cycle as the ss_n rise still
          // completes the frame, so it is tested before the abort case.
          if (sclk_rise && bit_cnt == LAST_BIT) begin
            o_counter <= shreg_next[COUNTER_W-1:0];
            o_valid   <= 1'b1;
            state     <= ss_rise ? IDLE : WAIT_CS;
          end else if (ss_rise) begin
            o_frame_err <= 1'b1;
            state       <= IDLE;
          end
        end

        WAIT_CS: begin
          if (ss_rise) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

`ifdef SPI_MISO_ECHO_EN
  logic [FRAME_BITS-1:0] tx;

  // Loaded at frame start with the value currently held, so the master reads
  // back what it sent in the previous frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx <= '0;
    end else if (state == IDLE && ss_fall) begin
      tx <= {{(FRAME_BITS-COUNTER_W){1'b0}}, o_counter};
    end else if (state != IDLE && sclk_fall) begin
      tx <= {tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign miso = tx[FRAME_BITS-1];

  logic unused_edges;
  assign unused_edges = mosi_rise ^ mosi_fall ^ sclk_level ^ ss_level;
`else
  assign miso = 1'b0;

  logic unused_edges;
  assign unused_edges = mosi_rise ^ mosi_fall ^ sclk_level ^ ss_level ^ sclk_fall;
`endif

endmodule

// File: tb/tb_spi_upcounter_slave.sv
// tb/tb_spi_upcounter_slave.sv - directed self-checking bench for spi_upcounter_slave
module tb_spi_upcounter_slave;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        ss_n;
  logic        miso;
  logic [13:0] o_counter;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_busy;

  int checks;
  int errors;
  int valid_cnt;
  int err_cnt;

  logic [15:0] rx_miso;
  logic [15:0] echo_exp;

  spi_upcounter_slave dut (
    .clk(clk),
    .reset(reset),
    .sclk(sclk),
    .mosi(mosi),
    .ss_n(ss_n),
    .miso(miso),
    .o_counter(o_counter),
    .o_valid(o_valid),
    .o_frame_err(o_frame_err),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: a correct pulse is high for exactly one clk.
  always @(negedge clk) begin
    if (o_valid)     valid_cnt = valid_cnt + 1;
    if (o_frame_err) err_cnt   = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SS assertion carrying nbits MSB-first; sclk is 10x slower than clk.
  // merge_end raises ss_n together with the last sclk rise.
  task automatic send_frame(input logic [15:0] data, input int nbits,
                            input bit merge_end, input int gap_clks,
                            output logic [15:0] miso_bits);
    miso_bits = '0;
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[15-i];
      #50;
      miso_bits[15-i] = miso;
      sclk = 1'b1;
      if (merge_end && i == nbits - 1) ss_n = 1'b1;
      #50;
      sclk = 1'b0;
    end
    if (!merge_end) begin
      #50;
      ss_n = 1'b1;
    end
    #(gap_clks * 10);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    reset     = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    ss_n      = 1'b1;
`ifdef SPI_MISO_ECHO_EN
    echo_exp  = 16'h1ABC;
`else
    echo_exp  = 16'h0000;
`endif

    repeat (3) @(negedge clk);
    check("reset_counter", 16'(o_counter), 16'h0000);
    check("reset_valid",   16'(o_valid),   16'h0000);
    check("reset_err",     16'(o_frame_err), 16'h0000);
    check("reset_busy",    16'(o_busy),    16'h0000);
    check("reset_miso",    16'(miso),      16'h0000);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // sclk activity with ss_n high must be ignored
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1; #50; sclk = 1'b0; #50;
    end
    check("idle_sclk_valid", 16'(valid_cnt), 16'd0);
    check("idle_sclk_busy",  16'(o_busy),    16'h0000);

    // plain frame
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h2A5B, 16, 1'b0, 10, rx_miso);
    check("f2A5B_counter", 16'(o_counter), 16'h2A5B);
    check("f2A5B_valid",   16'(valid_cnt), 16'd1);
    check("f2A5B_err",     16'(err_cnt),   16'd0);

    // pad bits set are discarded
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'hC123, 16, 1'b0, 10, rx_miso);
    check("fC123_counter", 16'(o_counter), 16'h0123);
    check("fC123_valid",   16'(valid_cnt), 16'd1);

    // good frame followed by a 9-bit aborted frame
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h1234, 16, 1'b0, 10, rx_miso);
    check("f1234_counter", 16'(o_counter), 16'h1234);
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h3FFF, 9, 1'b0, 10, rx_miso);
    check("abort_err",     16'(err_cnt),   16'd1);
    check("abort_valid",   16'(valid_cnt), 16'd0);
    check("abort_counter", 16'(o_counter), 16'h1234);
    check("abort_busy",    16'(o_busy),    16'h0000);

    // wrap value then zero with a 5-clk ss_n gap
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h3FFF, 16, 1'b0, 5, rx_miso);
    check("b2b_first_counter", 16'(o_counter), 16'h3FFF);
    send_frame(16'h0000, 16, 1'b0, 10, rx_miso);
    check("b2b_valid",   16'(valid_cnt), 16'd2);
    check("b2b_err",     16'(err_cnt),   16'd0);
    check("b2b_counter", 16'(o_counter), 16'h0000);

    // ss_n rise coincident with the 16th sclk rise completes the frame
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h0777, 16, 1'b1, 10, rx_miso);
    check("merge_counter", 16'(o_counter), 16'h0777);
    check("merge_valid",   16'(valid_cnt), 16'd1);
    check("merge_err",     16'(err_cnt),   16'd0);

    // reset partway through a frame, then a clean frame
    valid_cnt = 0; err_cnt = 0;
    ss_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      #50; sclk = 1'b1; #50; sclk = 1'b0;
    end
    check("midframe_busy", 16'(o_busy), 16'h0001);
    reset = 1'b1;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    #30;
    reset = 1'b0;
    #100;
    check("rst_err",     16'(err_cnt),   16'd0);
    check("rst_valid",   16'(valid_cnt), 16'd0);
    check("rst_counter", 16'(o_counter), 16'h0000);
    check("rst_busy",    16'(o_busy),    16'h0000);
    send_frame(16'h0005, 16, 1'b0, 10, rx_miso);
    check("f0005_counter", 16'(o_counter), 16'h0005);
    check("f0005_valid",   16'(valid_cnt), 16'd1);
    check("f0005_err",     16'(err_cnt),   16'd0);

    // readback of the previous value on miso (0 when echo is not built)
    send_frame(16'h1ABC, 16, 1'b0, 10, rx_miso);
    check("f1ABC_counter", 16'(o_counter), 16'h1ABC);
    send_frame(16'h0000, 16, 1'b0, 10, rx_miso);
    check("echo_miso", rx_miso, echo_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_upcounter_slave.md
# spi_upcounter_slave

SPI mode-0 slave that receives the 14-bit up-counter value sent by the SPI master side of the counter system and presents it, held and validated, to the display path. It oversamples SCLK/MOSI/SS in the `clk` domain, reassembles one 16-bit frame per SS assertion, and updates `o_counter` only on complete frames. It is the receiving end of the counter link.

## Interface
- `COUNTER_W`, 14: width of the reassembled counter value.
- `FRAME_BITS`, 16: bits per frame (two bytes).
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `mosi` and `ss_n`.

Ports:
- `clk`  input  1  system clock. One clock only; reset is asynchronous and active-high.
- `reset`  input  1  asynchronous, active-high reset.
- `sclk`  input  1  SPI clock from master (asynchronous to `clk`).
- `mosi`  input  1  serial data from master, MSB first.
- `ss_n`  input  1  slave select, active-low.
- `miso`  output  1  serial data to master (see Configuration).
- `o_counter`  output  14  last complete received counter value.
- `o_valid`  output  1  1-cycle pulse when `o_counter` updates.
- `o_frame_err`  output  1  1-cycle pulse on aborted frame.
- `o_busy`  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Frame: byte0 = {2 pad bits, counter[13:8]}, byte1 = counter[7:0], MSB first, 16 bits total. Pad bits are received and discarded.
- Mode 0: MOSI is sampled on the synchronized SCLK rising edge. MISO changes on the SCLK falling edge.
- The FSM has three states:
  - IDLE: on the synchronized `ss_n` falling edge, clear `bit_cnt` and the shift register, then go to SHIFT.
  - SHIFT: on each SCLK rise, `shreg <= {shreg[14:0], mosi}` and `bit_cnt++`. On the 16th rise, load `o_counter <= {shreg[12:0], mosi}` (low 14 bits), pulse `o_valid`, and go to WAIT_CS. If `ss_n` rises with `bit_cnt` < 16, pulse `o_frame_err`, leave `o_counter` unchanged, and go to IDLE.
  - WAIT_CS: ignore extra SCLK edges. On the `ss_n` rise, go to IDLE. No error is flagged.
- An `ss_n` rise and the 16th SCLK rise detected in the same `clk` cycle counts as a complete frame: `o_valid` pulses and there is no error.
- SCLK edges while in IDLE (`ss_n` high) are ignored.
- `bit_cnt` is 5 bits wide and saturates at 16. It never wraps.
- `o_counter` holds its value between frames. Counter wrap-around on the master side (3FFF→0000) arrives as an ordinary value.
- Reset at any time:
  - FSM goes to IDLE; `bit_cnt`, `shreg` and synchronizers clear.
  - A partial frame is dropped silently (no `o_frame_err`).

## Timing
- Requirement: `clk` frequency ≥ 8 × `sclk` frequency. SCLK high and low times must each be ≥ 3 `clk` periods.
- Edge detect compares the last two synchronizer outputs. A pin edge is seen `SYNC_STAGES`+1 `clk` cycles later.
- `o_valid` and the new `o_counter` appear 1 `clk` after the cycle in which the 16th SCLK rise is detected. That is ≤ 4 `clk` after the pin edge with defaults.
- `o_frame_err` appears 1 `clk` after the `ss_n` rise is detected.
- Reset values:
  - `o_counter` = 0, `o_valid` = 0, `o_frame_err` = 0, `o_busy` = 0.
  - `miso` = 0.
- Back-to-back frames: the master must keep `ss_n` high for ≥ 4 `clk` between frames.

## Configuration
- `SPI_MISO_ECHO_EN` defined:
  - At the `ss_n` fall, a 16-bit tx register loads {2'b00, `o_counter`}.
  - `miso` presents tx[15] immediately and shifts on each synchronized SCLK fall.
  - The master therefore reads back the previously received value.
- `SPI_MISO_ECHO_EN` undefined: `miso` is constant 0 and the tx register is not built.

## Structure
- Package `spi_pkg` holds:
  - the `COUNTER_W` and `FRAME_BITS` constants;
  - the `spi_slave_state_e` typedef {IDLE, SHIFT, WAIT_CS};
  - the frame pad width (2).
- One sub-module, `spi_sync_edge`:
  - `SYNC_STAGES` flop synchronizer plus rise/fall pulse outputs;
  - instantiated three times (`sclk`, `mosi`, `ss_n`); for `mosi` the level output is used.

## Test plan
- Send frame 0x2A5B (counter 0x2A5B) with `clk` = 10× `sclk` → one `o_valid` pulse; `o_counter` = 0x2A5B; `o_frame_err` = 0.
- Send 0xC123 (pad bits set) → `o_counter` = 0x0123; `o_valid` pulses once.
- Send 0x1234, then a 9-bit frame aborted by `ss_n` rise → `o_frame_err` pulses once; `o_counter` stays 0x1234; no `o_valid`.
- Send 0x3FFF then 0x0000 back-to-back with minimal `ss_n` gap → two `o_valid` pulses; `o_counter` ends at 0x0000.
- Assert `reset` after bit 7 of a frame, then send 0x0005 → no error pulse; only `o_counter` = 0x0005 is reported.
- With `SPI_MISO_ECHO_EN`: receive 0x1ABC, then clock a second frame → master samples 0x1ABC on `miso`.
